// File: rtl/alu_uart_frame_ctrl_if.sv
// UART/ALU-side signal bundle for alu_uart_frame_ctrl.
// The slave modport is the controller; the master modport is the UART/ALU side.
interface alu_uart_frame_ctrl_if #(
  parameter int NB_BYTE = 8,
  parameter int NB_DATA = 16,
  parameter int NB_OP   = 6
);
  logic               i_rx_done;
  logic [NB_BYTE-1:0] i_rx_data;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_data_one;
  logic [NB_DATA-1:0] o_data_two;
  logic [NB_OP-1:0]   o_operation;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_busy;
  logic               o_frame_err;

  modport slave (
    input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    output o_data_one, o_data_two, o_operation, o_tx_start, o_tx_data, o_busy, o_frame_err
  );

  modport master (
    output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
    input  o_data_one, o_data_two, o_operation, o_tx_start, o_tx_data, o_busy, o_frame_err
  );
endinterface

// File: rtl/alu_uart_frame_ctrl.sv
// Frames two multi-byte operands plus an opcode from UART rx into the ALU and sends the result back.
// Define ALU_UART_TIMEOUT_EN to discard partial frames after TIMEOUT_CYC idle cycles.
//
// state   | meaning
// S_OP1   | collect N_BYTES of operand A
// S_OP2   | collect N_BYTES of operand B
// S_OPC   | collect the opcode byte
// S_LATCH | capture ALU result, reset byte index
// S_SEND  | request transmission of result byte[index]
// S_WAIT  | wait for transmitter completion
module alu_uart_frame_ctrl #(
  parameter int NB_BYTE     = 8,
  parameter int NB_DATA     = 16,
  parameter int NB_OP       = 6,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  alu_uart_frame_ctrl_if.slave  bus
);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_OP1, S_OP2, S_OPC, S_LATCH, S_SEND, S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NB_DATA-1:0] shadow_q, shadow_d;
  logic [NB_DATA-1:0] data_one_q, data_one_d;
  logic [NB_DATA-1:0] data_two_q, data_two_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] res_q, res_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic [NB_DATA-1:0] assembled;
  logic               busy;
  logic               accept;
  logic               expire;

  assign busy   = (state_q == S_LATCH) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign accept = bus.i_rx_done && !busy;

  always_comb begin
    assembled = shadow_q;
    assembled[int'(cnt_q)*NB_BYTE +: NB_BYTE] = bus.i_rx_data;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    data_one_d = data_one_q;
    data_two_d = data_two_q;
    op_d       = op_q;
    res_d      = res_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_OP1, S_OP2: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            // Operands are committed whole so the ALU never sees a partial value.
            if (state_q == S_OP1) begin
              data_one_d = assembled;
              state_d    = S_OP2;
            end else begin
              data_two_d = assembled;
              state_d    = S_OPC;
            end
            shadow_d = '0;
            cnt_d    = '0;
          end else begin
            shadow_d = assembled;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      S_OPC: begin
        if (accept) begin
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        res_d   = bus.i_alu_result;
        cnt_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = res_q[int'(cnt_q)*NB_BYTE +: NB_BYTE];
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_tx_done) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_OP1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SEND;
          end
        end
      end
      default: state_d = S_OP1;
    endcase
    if (expire) begin
      shadow_d = '0;
      cnt_d    = '0;
      state_d  = S_OP1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_OP1;
      cnt_q      <= '0;
      shadow_q   <= '0;
      data_one_q <= '0;
      data_two_q <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      data_one_q <= data_one_d;
      data_two_q <= data_two_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

`ifdef ALU_UART_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_err_q;
  logic             partial;

  assign partial = ((state_q == S_OP1) && (cnt_q != '0)) || (state_q == S_OP2) || (state_q == S_OPC);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire  = partial && !accept && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (accept || !partial || expire) tmo_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      frame_err_q <= expire;
    end
  end

  assign bus.o_frame_err = frame_err_q;
`else
  // Keeps the timeout parameter referenced when the counter is not built.
  logic unused_timeout;
  assign unused_timeout  = (TIMEOUT_CYC < 0);
  assign expire          = 1'b0;
  assign bus.o_frame_err = 1'b0;
`endif

  assign bus.o_data_one  = data_one_q;
  assign bus.o_data_two  = data_two_q;
  assign bus.o_operation = op_q;
  assign bus.o_tx_start  = tx_start_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_busy      = busy;
endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// Directed bench for alu_uart_frame_ctrl with NB_DATA=16; the timeout sequence runs only when
// ALU_UART_TIMEOUT_EN is defined (TIMEOUT_CYC=100).
module tb_alu_uart_frame_ctrl;
  localparam int NB_BYTE = 8;
  localparam int NB_DATA = 16;
  localparam int NB_OP   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_pulses = 0;

  logic [15:0] prev_a = '0;
  logic [15:0] prev_b = '0;

  alu_uart_frame_ctrl_if #(.NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_uart_frame_ctrl #(
    .NB_BYTE(NB_BYTE), .NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_CYC(100)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu(input logic [15:0] a, input logic [15:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 16'h0000;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu(bus.o_data_one, bus.o_data_two, bus.o_operation);

  always @(negedge clk) if (bus.o_frame_err) err_pulses++;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  opb;
    logic [5:0]  exp_op;
    logic [15:0] exp_res;
    bit          junk;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] exp_byte;
    send_byte(v.a[7:0]);
    check("a_hold", bus.o_data_one, prev_a);
    send_byte(v.a[15:8]);
    check("a_commit", bus.o_data_one, v.a);
    send_byte(v.b[7:0]);
    check("b_hold", bus.o_data_two, prev_b);
    send_byte(v.b[15:8]);
    check("b_commit", bus.o_data_two, v.b);
    check("busy_idle", bus.o_busy, 1'b0);
    send_byte(v.opb);
    check("opcode", bus.o_operation, v.exp_op);
    check("busy_latch", bus.o_busy, 1'b1);
    tick();
    check("tx_start_k1", bus.o_tx_start, 1'b0);
    if (v.junk) bus.i_tx_done = 1'b1;
    tick();
    bus.i_tx_done = 1'b0;
    check("tx_start_k2", bus.o_tx_start, 1'b1);
    check("tx_byte0", bus.o_tx_data, v.exp_res[7:0]);
    tick();
    check("tx_start_pulse", bus.o_tx_start, 1'b0);
    if (v.junk) begin
      send_byte(8'h99);
      send_byte(8'h77);
      check("busy_wait", bus.o_busy, 1'b1);
      check("a_after_junk", bus.o_data_one, v.a);
      check("no_restart", bus.o_tx_start, 1'b0);
    end
    for (int i = 1; i <= 2; i++) begin
      bus.i_tx_done = 1'b1;
      tick();
      bus.i_tx_done = 1'b0;
      if (i < 2) begin
        exp_byte = v.exp_res[15:8];
        check("turnaround", bus.o_tx_start, 1'b0);
        tick();
        check("tx_start_next", bus.o_tx_start, 1'b1);
        check("tx_byte1", bus.o_tx_data, exp_byte);
        tick();
        check("tx_start_pulse1", bus.o_tx_start, 1'b0);
      end else begin
        check("busy_done", bus.o_busy, 1'b0);
      end
    end
    prev_a = v.a;
    prev_b = v.b;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{16'h1234, 16'h0001, 8'h20, 6'h20, 16'h1235, 1'b0};
    vecs[1] = '{16'h006F, 16'h0020, 8'h24, 6'h24, 16'h0020, 1'b0};
    vecs[2] = '{16'h0064, 16'h000A, 8'h20, 6'h20, 16'h006E, 1'b1};
    vecs[3] = '{16'h0005, 16'h0003, 8'hE2, 6'h22, 16'h0002, 1'b0};
    vecs[4] = '{16'hF0F0, 16'h0FF0, 8'h25, 6'h25, 16'hFFF0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0001, 8'h20, 6'h20, 16'h0000, 1'b1};
    vecs[6] = '{16'hAAAA, 16'h5555, 8'h66, 6'h26, 16'hFFFF, 1'b0};
    vecs[7] = '{16'h1200, 16'h0034, 8'h27, 6'h27, 16'hEDCB, 1'b0};

    bus.i_rx_done = 1'b0;
    bus.i_rx_data = '0;
    bus.i_tx_done = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data_one", bus.o_data_one, 16'h0);
    check("rst_data_two", bus.o_data_two, 16'h0);
    check("rst_operation", bus.o_operation, 6'h0);
    check("rst_tx_start", bus.o_tx_start, 1'b0);
    check("rst_tx_data", bus.o_tx_data, 8'h0);
    check("rst_busy", bus.o_busy, 1'b0);
    check("rst_frame_err", bus.o_frame_err, 1'b0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Reset after three bytes of a five-byte frame.
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("mid_a_commit", bus.o_data_one, 16'h2211);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_data_one", bus.o_data_one, 16'h0);
    check("midrst_data_two", bus.o_data_two, 16'h0);
    check("midrst_operation", bus.o_operation, 6'h0);
    check("midrst_tx_data", bus.o_tx_data, 8'h0);
    check("midrst_busy", bus.o_busy, 1'b0);
    prev_a = '0;
    prev_b = '0;
    run_frame(vecs[0]);

`ifdef ALU_UART_TIMEOUT_EN
    send_byte(8'h34);
    for (int i = 0; i < 105; i++) tick();
    check("timeout_pulses", err_pulses, 1);
    check("timeout_a_kept", bus.o_data_one, 16'h1234);
    check("timeout_busy", bus.o_busy, 1'b0);
    v = '{16'h0005, 16'h0003, 8'h20, 6'h20, 16'h0008, 1'b0};
    run_frame(v);
    check("err_pulses_total", err_pulses, 1);
`else
    v = '{16'h0005, 16'h0003, 8'h20, 6'h20, 16'h0008, 1'b0};
    run_frame(v);
    check("err_pulses_total", err_pulses, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_uart_frame_ctrl.md
# alu_uart_frame_ctrl

Parametrised framing controller between the UART receiver/transmitter and the combinational ALU. It assembles two multi-byte operands and one opcode byte from the UART receive stream and drives them to the ALU. It then serialises the ALU result back to the UART transmitter byte by byte, with a handshake on transmitter completion. It is the next generation of the single-byte interface circuit and adds operand width scaling, transmit flow control and an optional inter-byte timeout.

## Interface
- NB_BYTE, 8: UART character width.
- NB_DATA, 16: ALU operand/result width; integer multiple of NB_BYTE; N_BYTES = NB_DATA/NB_BYTE (1..8).
- NB_OP, 6: ALU opcode width; ≤ NB_BYTE; taken from the low NB_OP bits of the opcode byte.
- TIMEOUT_CYC, 50000: inter-byte timeout in clock cycles (used only with the timeout macro).

Ports, clock and reset first; clock and reset: one clock; reset is synchronous and active-high.
- i_clk  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_done  in  1  one-cycle pulse; i_rx_data valid.
- i_rx_data  in  NB_BYTE  received character.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done  in  1  one-cycle pulse; transmitter finished the current character.
- o_data_one  out  NB_DATA  operand A to ALU.
- o_data_two  out  NB_DATA  operand B to ALU.
- o_operation  out  NB_OP  opcode to ALU.
- o_tx_start  out  1  one-cycle transmit request.
- o_tx_data  out  NB_BYTE  character to transmit; stable from o_tx_start until i_tx_done.
- o_busy  out  1  high while a result is being latched or sent.
- o_frame_err  out  1  one-cycle pulse when a partial frame is discarded on timeout.

## Operation
- States:
  - S_OP1: collect N_BYTES of operand A.
  - S_OP2: collect N_BYTES of operand B.
  - S_OPC: collect 1 opcode byte.
  - S_LATCH: capture the result.
  - S_SEND: request transmission.
  - S_WAIT: wait for transmitter completion.
- Reset values: state S_OP1, byte counter 0, all data outputs 0, o_tx_start 0, o_busy 0, o_frame_err 0.
- Operand bytes arrive LSB first and are assembled in a shadow register.
- o_data_one and o_data_two update only on acceptance of the last byte of their operand. The ALU therefore never sees a half-built operand.
- The previous operand and opcode values are held until overwritten.
- S_OPC: an accepted byte loads o_operation = i_rx_data[NB_OP-1:0], then the state moves to S_LATCH. Upper opcode bits are ignored.
- S_LATCH: one cycle; i_alu_result is copied into the result shift register, byte index 0, then the state moves to S_SEND.
- S_SEND: one cycle; o_tx_start = 1, o_tx_data = result byte[index], then the state moves to S_WAIT.
- S_WAIT, on i_tx_done:
  - if index = N_BYTES-1, go to S_OP1;
  - otherwise index+1 and go to S_SEND.
  - Result bytes are sent LSB first.
- o_busy = 1 in S_LATCH, S_SEND and S_WAIT.
- i_rx_done while o_busy = 1 is dropped; the byte is not buffered.
- i_tx_done outside S_WAIT, including during S_SEND, is ignored.
- Reset mid-frame or mid-transmit: immediate return to the reset values; the partial frame and any pending result are discarded.

## Timing
- i_rx_done is sampled on the rising edge of i_clk; the byte is accepted at edge k.
- Operand commit is visible from edge k.
- Opcode accepted at edge k:
  - o_operation valid after edge k;
  - result captured at edge k+1;
  - o_tx_start high for exactly one cycle, from edge k+2 to edge k+3.
- Next character: o_tx_start rises on the edge following the i_tx_done edge, one cycle of turnaround.
- First operand byte of the next frame: accepted in the cycle after the final i_tx_done edge.

## Configuration
- Macro ALU_UART_TIMEOUT_EN.
- Defined:
  - a counter clears on every accepted byte;
  - it counts while a frame is partially received (S_OP1 with counter>0, S_OP2, or S_OPC);
  - on reaching TIMEOUT_CYC-1: shadow and byte counter are cleared, state goes to S_OP1, o_frame_err pulses one cycle, and committed outputs are unchanged.
  - If i_rx_done coincides with expiry, the byte is accepted and no error is raised.
- Not defined: no counter is synthesised; o_frame_err is tied to 0; a partial frame waits indefinitely.

## Test plan
- NB_DATA=8:
  - Rx 0x64, 0x0A, 0x20 (ADD) -> o_data_one=0x64, o_data_two=0x0A, o_operation=0x20; one o_tx_start with o_tx_data=0x6E, two cycles after the opcode byte.
  - Rx 0x6F, 0x20, 0x24 (AND) -> o_tx_data=0x20.
- NB_DATA=16: rx 0x34, 0x12, 0x01, 0x00, 0x20 -> o_data_one=0x1234, o_data_two=0x0001.
  - Tx 0x35; then, only after i_tx_done, tx 0x12; then return to S_OP1.
- Bytes pulsed during S_WAIT -> ignored; the next frame decodes correctly from its first byte.
- Reset asserted after 3 of 5 bytes -> all outputs 0; a fresh 5-byte frame produces the correct result.
- ALU_UART_TIMEOUT_EN, TIMEOUT_CYC=100:
  - rx 0x34 then idle for 100 cycles -> o_frame_err pulses once;
  - the following full frame 0x05, 0x00, 0x03, 0x00, 0x20 -> tx 0x08, 0x00.
